// File: rtl/vec_normalize.sv
// -----------------------------------------------------------------------------
// vec_normalize
// Ray-direction normaliser. Squares and sums the three signed fixed-point
// components, forms an even-shifted address into an external 1/sqrt BRAM,
// then scales every component by the returned word so the result has unit
// length in the same Q format as the input.
//
// Pipeline (one vector per cycle, every stage stalls together):
//   S0 capture -> S1 squares -> S2 sum/shift/addr -> S3 LUT data (BRAM reg)
//   -> S4 products -> S5 output registers
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    input handshake
//   in_x/in_y/in_z       signed components, Q(COORD_WIDTH-FRAC_BITS).FRAC_BITS
//   out_valid/out_ready  output handshake
//   out_x/out_y/out_z    normalised components, same Q format as the inputs
//   out_zero             result came from an all-zero vector
//   lut_addr/lut_en      read port of the invsqrt BRAM (driven from S2)
//   lut_data             BRAM output register, valid one clock after lut_en
// -----------------------------------------------------------------------------
module vec_normalize #(
   parameter int COORD_WIDTH = 32,
   parameter int FRAC_BITS   = 16,
   parameter int ADDR_LENGTH = 12,
   parameter int DATA_WIDTH  = 32,
   parameter int LUT_FRAC    = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [COORD_WIDTH-1:0] in_x,
   input  logic signed [COORD_WIDTH-1:0] in_y,
   input  logic signed [COORD_WIDTH-1:0] in_z,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [COORD_WIDTH-1:0] out_x,
   output logic signed [COORD_WIDTH-1:0] out_y,
   output logic signed [COORD_WIDTH-1:0] out_z,
   output logic                          out_zero,
   output logic [ADDR_LENGTH-1:0]        lut_addr,
   output logic                          lut_en,
   input  logic [DATA_WIDTH-1:0]         lut_data
);

   localparam int SQ_W       = 2 * COORD_WIDTH;
   localparam int SUM_W      = 2 * COORD_WIDTH + 2;
   localparam int PROD_W     = COORD_WIDTH + DATA_WIDTH + 1;
   localparam int H_W        = $clog2(SUM_W) + 1;
   localparam int BASE_SHIFT = LUT_FRAC - FRAC_BITS;

   localparam logic signed [PROD_W-1:0] SAT_MAX =
      {{(PROD_W-COORD_WIDTH+1){1'b0}}, {(COORD_WIDTH-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] SAT_MIN =
      {{(PROD_W-COORD_WIDTH+1){1'b1}}, {(COORD_WIDTH-1){1'b0}}};

   typedef struct packed {
      logic                   valid;
      logic [COORD_WIDTH-1:0] x, y, z;
   } s0_t;

   typedef struct packed {
      logic                   valid;
      logic [COORD_WIDTH-1:0] x, y, z;
      logic [SQ_W-1:0]        xx, yy, zz;
   } s1_t;

   typedef struct packed {
      logic                   valid;
      logic                   zero;
      logic [H_W-1:0]         h;
      logic [ADDR_LENGTH-1:0] addr;
      logic [COORD_WIDTH-1:0] x, y, z;
   } s2_t;

   typedef struct packed {
      logic                   valid;
      logic                   zero;
      logic [H_W-1:0]         h;
      logic [COORD_WIDTH-1:0] x, y, z;
   } s3_t;

   typedef struct packed {
      logic                   valid;
      logic                   zero;
      logic [H_W-1:0]         h;
      logic [PROD_W-1:0]      px, py, pz;
   } s4_t;

   typedef struct packed {
      logic                   valid;
      logic                   zero;
      logic [COORD_WIDTH-1:0] x, y, z;
   } s5_t;

   s0_t s0_d, s0_q;
   s1_t s1_d, s1_q;
   s2_t s2_d, s2_q;
   s3_t s3_d, s3_q;
   s4_t s4_d, s4_q;
   s5_t s5_d, s5_q;

   logic             stall;
   logic [SUM_W-1:0] sum;
   int               msb;
   int               h_raw;
   int               h_even;

   // Exact signed square; (-2^(W-1))^2 still fits as a positive SQ_W value.
   function automatic logic [SQ_W-1:0] square(input logic [COORD_WIDTH-1:0] c);
      logic signed [SQ_W-1:0] sq;
      sq = $signed(c) * $signed(c);
      return sq;
   endfunction

   // Undo the LUT scaling plus half the address shift, then clamp.
   function automatic logic [COORD_WIDTH-1:0] scale(input logic [PROD_W-1:0] prod,
                                                    input logic [H_W-1:0]    h);
      logic signed [PROD_W-1:0] shifted;
      shifted = $signed(prod) >>> (BASE_SHIFT + int'(h >> 1));
      if (shifted > SAT_MAX) begin
         return SAT_MAX[COORD_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         return SAT_MIN[COORD_WIDTH-1:0];
      end
      return shifted[COORD_WIDTH-1:0];
   endfunction

   assign stall    = s5_q.valid && !out_ready;
   assign in_ready = !stall;

   // The BRAM output register is the S3 data register; it only changes when
   // lut_en is high, so holding lut_en low during a stall freezes it.
   assign lut_en   = !stall && s2_q.valid && !s2_q.zero;
   assign lut_addr = s2_q.addr;

   assign out_valid = s5_q.valid;
   assign out_zero  = s5_q.zero;
   assign out_x     = s5_q.x;
   assign out_y     = s5_q.y;
   assign out_z     = s5_q.z;

   always_comb begin
      // NOTE: every stage defaults to holding its value, so each variable is
      // assigned on all paths and no latch is inferred.
      s0_d = s0_q;
      s1_d = s1_q;
      s2_d = s2_q;
      s3_d = s3_q;
      s4_d = s4_q;
      s5_d = s5_q;

      sum = SUM_W'(s1_q.xx) + SUM_W'(s1_q.yy) + SUM_W'(s1_q.zz);

      msb = 0;
      for (int i = 0; i < SUM_W; i++) begin
         if (sum[i]) msb = i;
      end
      // Smallest even shift that brings S into the LUT address range; the
      // even value keeps 1/sqrt(2^h) an exact power of two (2^(h/2)).
      h_raw  = (msb >= ADDR_LENGTH) ? (msb - ADDR_LENGTH + 1) : 0;
      h_even = h_raw + (h_raw % 2);

      if (!stall) begin
         s0_d.valid = in_valid;
         s0_d.x     = in_x;
         s0_d.y     = in_y;
         s0_d.z     = in_z;

         s1_d.valid = s0_q.valid;
         s1_d.x     = s0_q.x;
         s1_d.y     = s0_q.y;
         s1_d.z     = s0_q.z;
         s1_d.xx    = square(s0_q.x);
         s1_d.yy    = square(s0_q.y);
         s1_d.zz    = square(s0_q.z);

         s2_d.valid = s1_q.valid;
         s2_d.zero  = (sum == '0);
         s2_d.h     = H_W'(h_even);
         s2_d.addr  = ADDR_LENGTH'(sum >> h_even);
         s2_d.x     = s1_q.x;
         s2_d.y     = s1_q.y;
         s2_d.z     = s1_q.z;

         s3_d.valid = s2_q.valid;
         s3_d.zero  = s2_q.zero;
         s3_d.h     = s2_q.h;
         s3_d.x     = s2_q.x;
         s3_d.y     = s2_q.y;
         s3_d.z     = s2_q.z;

         // Signed component times unsigned LUT word (zero-extended).
         s4_d.valid = s3_q.valid;
         s4_d.zero  = s3_q.zero;
         s4_d.h     = s3_q.h;
         s4_d.px    = $signed(s3_q.x) * $signed({1'b0, lut_data});
         s4_d.py    = $signed(s3_q.y) * $signed({1'b0, lut_data});
         s4_d.pz    = $signed(s3_q.z) * $signed({1'b0, lut_data});

         s5_d.valid = s4_q.valid;
         if (s4_q.valid) begin
            // A zero vector never read the LUT, so its product is ignored.
            s5_d.zero = s4_q.zero;
            s5_d.x    = s4_q.zero ? '0 : scale(s4_q.px, s4_q.h);
            s5_d.y    = s4_q.zero ? '0 : scale(s4_q.py, s4_q.h);
            s5_d.z    = s4_q.zero ? '0 : scale(s4_q.pz, s4_q.h);
         end
      end
   end

   // NOTE: data fields are reset along with the valids because the outputs
   // and lut_addr come straight from these registers and must read 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_q <= '0;
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
         s4_q <= '0;
         s5_q <= '0;
      end else begin
         // NOTE: non-blocking updates let every stage read the pre-edge value
         // of its predecessor, which is what makes this a pipeline.
         s0_q <= s0_d;
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
         s4_q <= s4_d;
         s5_q <= s5_d;
      end
   end

endmodule

// File: tb/tb_vec_normalize.sv
// -----------------------------------------------------------------------------
// tb_vec_normalize
// Scoreboard bench for vec_normalize. Stimulus pushes the reference result
// (and expected LUT address) when a vector is accepted; a monitor on the
// falling edge pops and compares whenever the DUT presents a result or a
// LUT read. A 1-cycle BRAM model holds round(65536/sqrt(a)).
// -----------------------------------------------------------------------------
module tb_vec_normalize;

   localparam int CW = 32;
   localparam int FB = 16;
   localparam int AL = 12;
   localparam int DW = 32;
   localparam int LF = 16;

   localparam logic signed [127:0] LUT_DEPTH = 128'sd1 <<< AL;
   localparam logic signed [127:0] SMAX      = 128'sd2147483647;
   localparam logic signed [127:0] SMIN      = -SMAX - 128'sd1;

   logic                 clk       = 1'b0;
   logic                 rst_n     = 1'b0;
   logic                 in_valid  = 1'b0;
   logic                 in_ready;
   logic signed [CW-1:0] in_x      = '0;
   logic signed [CW-1:0] in_y      = '0;
   logic signed [CW-1:0] in_z      = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic signed [CW-1:0] out_x, out_y, out_z;
   logic                 out_zero;
   logic [AL-1:0]        lut_addr;
   logic                 lut_en;
   logic [DW-1:0]        lut_data  = '0;

   always #5 clk = ~clk;

   vec_normalize #(
      .COORD_WIDTH(CW), .FRAC_BITS(FB), .ADDR_LENGTH(AL),
      .DATA_WIDTH(DW),  .LUT_FRAC(LF)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_z(in_z),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_zero(out_zero),
      .lut_addr(lut_addr), .lut_en(lut_en), .lut_data(lut_data)
   );

   // 1-cycle-latency BRAM; output holds while lut_en is low
   logic [DW-1:0] lut_mem [0:(1<<AL)-1];
   always @(posedge clk) if (lut_en) lut_data <= lut_mem[lut_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input bit ok, input longint act, input longint exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   typedef struct {
      logic signed [CW-1:0] x, y, z;
      logic                 zero;
      int                   acc;
      bit                   chk_lat;
   } exp_t;

   exp_t          sb[$];
   logic [AL-1:0] addr_q[$];
   bit            lat_mode = 1'b0;
   bit            done     = 1'b0;

   // Reference: exact 128-bit arithmetic; shift S by the smallest even h that
   // makes it index the table, scale by the table word and by 2^(h/2).
   task automatic model(input logic signed [CW-1:0] x, y, z,
                        output exp_t e, output logic [AL-1:0] a);
      logic signed [127:0] c [3];
      logic signed [127:0] s, p;
      logic signed [CW-1:0] r [3];
      logic [DW-1:0] l;
      int h;
      c[0] = x; c[1] = y; c[2] = z;
      s = c[0] * c[0] + c[1] * c[1] + c[2] * c[2];
      h = 0;
      while ((s >>> h) >= LUT_DEPTH) h += 2;
      a = AL'(s >>> h);
      l = lut_mem[a];
      for (int k = 0; k < 3; k++) begin
         p = c[k] * $signed({96'd0, l});
         p = p >>> ((LF - FB) + h / 2);
         if (s == 0)        r[k] = '0;
         else if (p > SMAX) r[k] = SMAX[CW-1:0];
         else if (p < SMIN) r[k] = SMIN[CW-1:0];
         else               r[k] = p[CW-1:0];
      end
      e.x = r[0]; e.y = r[1]; e.z = r[2];
      e.zero = (s == 0);
      e.acc = 0;
      e.chk_lat = 1'b0;
   endtask

   function automatic logic signed [CW-1:0] rnd_c();
      logic signed [CW-1:0] v;
      int sel;
      v   = $signed($urandom);
      v   = v >>> $urandom_range(0, CW - 1);
      sel = $urandom_range(0, 15);
      if (sel == 0)      v = '0;
      else if (sel == 1) v = {1'b1, {(CW-1){1'b0}}};
      return v;
   endfunction

   // Present a vector from the falling edge; it is accepted at the next
   // rising edge where in_ready is high.
   task automatic send(input logic signed [CW-1:0] x, y, z);
      exp_t e;
      logic [AL-1:0] a;
      int guard;
      @(negedge clk);
      in_valid = 1'b1;
      in_x = x; in_y = y; in_z = z;
      #1;
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (!in_ready) begin
         check("accept_timeout", 1'b0, guard, 200);
      end else begin
         model(x, y, z, e, a);
         e.acc     = cyc + 1;
         e.chk_lat = lat_mode;
         sb.push_back(e);
         if (!e.zero) addr_q.push_back(a);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 400) begin
         @(negedge clk);
         g++;
      end
      if (sb.size() != 0) check("drain_timeout", 1'b0, sb.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   // Monitor
   bit                   hold_pend = 1'b0;
   logic signed [CW-1:0] hx, hy, hz;
   logic                 hzero;

   always @(negedge clk) begin
      exp_t e;
      logic [AL-1:0] a;
      #2;
      if (!rst_n) begin
         hold_pend = 1'b0;
      end else begin
         check("in_ready", in_ready == !(out_valid && !out_ready), in_ready, !(out_valid && !out_ready));
         if (hold_pend) begin
            check("hold_valid", out_valid == 1'b1, out_valid, 1);
            check("hold_x", out_x == hx, out_x, hx);
            check("hold_y", out_y == hy, out_y, hy);
            check("hold_z", out_z == hz, out_z, hz);
            check("hold_zero", out_zero == hzero, out_zero, hzero);
         end
         if (out_valid && !out_ready) check("lut_en_stall", lut_en == 1'b0, lut_en, 0);
         if (lut_en) begin
            if (addr_q.size() == 0) begin
               check("lut_en_unexpected", 1'b0, lut_addr, -1);
            end else begin
               a = addr_q.pop_front();
               check("lut_addr", lut_addr == a, lut_addr, a);
            end
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 1'b0, out_x, 0);
            end else begin
               e = sb.pop_front();
               check("out_x", out_x == e.x, out_x, e.x);
               check("out_y", out_y == e.y, out_y, e.y);
               check("out_z", out_z == e.z, out_z, e.z);
               check("out_zero", out_zero == e.zero, out_zero, e.zero);
               if (e.chk_lat) check("latency", (cyc - e.acc) == 5, cyc - e.acc, 5);
            end
         end
         hold_pend = out_valid && !out_ready;
         hx = out_x; hy = out_y; hz = out_z; hzero = out_zero;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      lut_mem[0] = 32'hDEAD_BEEF;
      for (int a = 1; a < (1 << AL); a++)
         lut_mem[a] = DW'($rtoi((2.0 ** LF) / $sqrt(real'(a)) + 0.5));

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
      check("rst_out_zero", out_zero == 1'b0, out_zero, 0);
      check("rst_out_x", out_x == 0, out_x, 0);
      check("rst_out_y", out_y == 0, out_y, 0);
      check("rst_out_z", out_z == 0, out_z, 0);
      check("rst_lut_en", lut_en == 1'b0, lut_en, 0);
      check("rst_lut_addr", lut_addr == 0, lut_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", in_ready == 1'b1, in_ready, 1);

      // Directed vectors with latency checking
      lat_mode = 1'b1;
      send(3 * 65536, 4 * 65536, 0);
      idle();
      drain();
      send(65536, 0, 0);
      send(1, 0, 0);
      idle();
      drain();
      send(-3 * 65536, -4 * 65536, 0);
      send(0, 0, 0);
      idle();
      drain();

      // Back-to-back stream: consecutive accepts, each at latency 5
      for (int i = 0; i < 8; i++) send(rnd_c(), rnd_c(), rnd_c());
      idle();
      drain();

      // Backpressure: pipeline fills, stalls, then drains in order
      lat_mode  = 1'b0;
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 10; i++) send(rnd_c(), rnd_c(), rnd_c());
            idle();
         end
         begin
            repeat (15) @(negedge clk);
            #3;
            check("stall_in_ready", in_ready == 1'b0, in_ready, 0);
            check("stall_out_valid", out_valid == 1'b1, out_valid, 1);
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();

      // Asynchronous reset while results are in flight
      lat_mode = 1'b1;
      for (int i = 0; i < 6; i++) send(rnd_c(), rnd_c(), rnd_c() | 32'sd1);
      @(posedge clk);
      #2;
      check("pre_reset_valid", out_valid == 1'b1, out_valid, 1);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("async_rst_valid", out_valid == 1'b0, out_valid, 0);
      check("async_rst_x", out_x == 0, out_x, 0);
      check("async_rst_lut_en", lut_en == 1'b0, lut_en, 0);
      sb.delete();
      addr_q.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      #3;
      check("post_reset_quiet", out_valid == 1'b0, out_valid, 0);
      check("post_reset_ready", in_ready == 1'b1, in_ready, 1);
      send(-65536, 2 * 65536, 2 * 65536);
      idle();
      drain();

      // Randomised traffic with random backpressure
      lat_mode = 1'b0;
      done     = 1'b0;
      fork
         begin
            for (int i = 0; i < 150; i++) send(rnd_c(), rnd_c(), rnd_c());
            idle();
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      drain();

      check("sb_empty", sb.size() == 0, sb.size(), 0);
      check("addr_q_empty", addr_q.size() == 0, addr_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
